// File: rtl/pc_pkg.sv
// Shared state type and width helpers for the program-counter sequencer.
// The extra carry bit lets the end-of-program test see an overflowing increment.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_IDLE,
    PC_RUN,
    PC_DONE
  } pc_state_t;

  localparam int PC_CARRY_BITS = 1;

  function automatic int pc_ext_width(input int width);
    return width + PC_CARRY_BITS;
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection while running: halt > branch > stall > increment.
// Also flags clamped branch targets and increments that run past the program bound.
module pc_next_calc
  import pc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STEP      = 1,
  parameter int RESET_VEC = 0,
  parameter int PROG_LAST = 15,
  parameter int WRAP_EN   = 0
) (
  input  logic [WIDTH-1:0] pc_cur,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             stall,
  input  logic             halt,
  output logic [WIDTH-1:0] pc_next,
  output logic             clamp,
  output logic             end_of_prog
);

  localparam int               EXT_W    = pc_ext_width(WIDTH);
  localparam logic [EXT_W-1:0] LAST_EXT = EXT_W'(PROG_LAST);
  localparam logic [EXT_W-1:0] STEP_EXT = EXT_W'(STEP);
  localparam logic [WIDTH-1:0] LAST_PC  = WIDTH'(PROG_LAST);
  localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VEC);

  logic [EXT_W-1:0] pc_inc;

  // Widened add so a carry out of WIDTH bits still compares as past the bound.
  assign pc_inc = {1'b0, pc_cur} + STEP_EXT;

  always_comb begin
    pc_next     = pc_cur;
    clamp       = 1'b0;
    end_of_prog = 1'b0;
    if (!halt) begin
      if (br_valid) begin
        if (br_target > LAST_PC) begin
          pc_next = LAST_PC;
          clamp   = 1'b1;
        end else begin
          pc_next = br_target;
        end
      end else if (!stall) begin
        if (pc_inc <= LAST_EXT) begin
          pc_next = pc_inc[WIDTH-1:0];
        end else begin
          end_of_prog = 1'b1;
          pc_next     = (WRAP_EN != 0) ? RESET_PC : pc_cur;
        end
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/DONE control around pc_next_calc.
// Every output comes straight from a flop, so inputs never reach outputs combinationally.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STEP      = 1,
  parameter int RESET_VEC = 0,
  parameter int PROG_LAST = 15,
  parameter int WRAP_EN   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             halt,
  output logic [WIDTH-1:0] pc_out,
  output logic             pc_valid,
  output logic             done,
  output logic             oob_err
);

  localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VEC);

  pc_state_t        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pc_valid_q, pc_valid_d;
  logic             done_q, done_d;
  logic             oob_err_q, oob_err_d;

  logic [WIDTH-1:0] pc_next;
  logic             clamp;
  logic             end_of_prog;

  pc_next_calc #(
    .WIDTH    (WIDTH),
    .STEP     (STEP),
    .RESET_VEC(RESET_VEC),
    .PROG_LAST(PROG_LAST),
    .WRAP_EN  (WRAP_EN)
  ) u_next_calc (
    .pc_cur     (pc_q),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .stall      (stall),
    .halt       (halt),
    .pc_next    (pc_next),
    .clamp      (clamp),
    .end_of_prog(end_of_prog)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    done_d     = done_q;
    oob_err_d  = 1'b0;
    case (state_q)
      PC_IDLE: begin
        pc_d       = RESET_PC;
        pc_valid_d = 1'b0;
        done_d     = 1'b0;
        if (start) begin
          state_d    = PC_RUN;
          pc_valid_d = 1'b1;
        end
      end
      PC_RUN: begin
        // A non-wrapping program that runs off the end parks on its last PC.
        if (halt || (end_of_prog && (WRAP_EN == 0))) begin
          state_d    = PC_DONE;
          pc_valid_d = 1'b0;
          done_d     = 1'b1;
        end else begin
          pc_d       = pc_next;
          pc_valid_d = 1'b1;
          done_d     = 1'b0;
          oob_err_d  = clamp;
        end
      end
      PC_DONE: begin
        if (start) begin
          state_d    = PC_RUN;
          pc_d       = RESET_PC;
          pc_valid_d = 1'b1;
          done_d     = 1'b0;
        end
      end
      default: begin
        state_d    = PC_IDLE;
        pc_d       = RESET_PC;
        pc_valid_d = 1'b0;
        done_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= PC_IDLE;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      done_q     <= 1'b0;
      oob_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      done_q     <= done_d;
      oob_err_q  <= oob_err_d;
    end
  end

  assign pc_out   = pc_q;
  assign pc_valid = pc_valid_q;
  assign done     = done_q;
  assign oob_err  = oob_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: three configurations share one stimulus stream and are
// checked every cycle against a behavioural model, plus hand-computed literals.
module tb_pc_sequencer;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       br_valid = 1'b0;
  logic [7:0] br_target = 8'd0;
  logic       halt = 1'b0;

  logic [7:0] pc_a, pc_b;
  logic [3:0] pc_c;
  logic       valid_a, valid_b, valid_c;
  logic       done_a, done_b, done_c;
  logic       oob_a, oob_b, oob_c;

  int total_checks = 0;
  int pass_checks  = 0;
  bit checking     = 1'b0;

  int mode_a, pc_m_a, mode_b, pc_m_b, mode_c, pc_m_c;
  bit oob_m_a, oob_m_b, oob_m_c;

  always #5 clk = ~clk;

  // Default configuration: 8-bit, stop at 15.
  pc_sequencer u_dut_a (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .br_valid(br_valid),
    .br_target(br_target), .halt(halt), .pc_out(pc_a), .pc_valid(valid_a),
    .done(done_a), .oob_err(oob_a)
  );

  // Short wrapping program.
  pc_sequencer #(.PROG_LAST(5), .WRAP_EN(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .br_valid(br_valid),
    .br_target(br_target), .halt(halt), .pc_out(pc_b), .pc_valid(valid_b),
    .done(done_b), .oob_err(oob_b)
  );

  // Narrow PC whose increment carries out of the register width.
  pc_sequencer #(.WIDTH(4), .STEP(3), .RESET_VEC(2), .PROG_LAST(15), .WRAP_EN(1)) u_dut_c (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .br_valid(br_valid),
    .br_target(br_target[3:0]), .halt(halt), .pc_out(pc_c), .pc_valid(valid_c),
    .done(done_c), .oob_err(oob_c)
  );

  task automatic checkOutput(input string name, input int act, input int req);
    total_checks++;
    if (act == req) pass_checks++;
    else $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
  endtask

  // Spec-level behaviour of one sequencer, using unbounded integer arithmetic.
  task automatic model_step(input int last, input bit wrap, input int step, input int rvec,
                            input int mask, inout int mode, inout int pc, output bit oob);
    int tgt;
    oob = 1'b0;
    tgt = int'(br_target) & mask;
    if (!rst) begin
      mode = M_IDLE;
      pc   = rvec;
    end else if (mode == M_IDLE || mode == M_DONE) begin
      if (start) begin
        mode = M_RUN;
        pc   = rvec;
      end
    end else if (halt) begin
      mode = M_DONE;
    end else if (br_valid) begin
      if (tgt > last) begin
        pc  = last;
        oob = 1'b1;
      end else begin
        pc = tgt;
      end
    end else if (!stall) begin
      if (pc + step <= last) pc = pc + step;
      else if (wrap) pc = rvec;
      else mode = M_DONE;
    end
  endtask

  always @(posedge clk) begin
    model_step(15, 1'b0, 1, 0, 255, mode_a, pc_m_a, oob_m_a);
    model_step(5, 1'b1, 1, 0, 255, mode_b, pc_m_b, oob_m_b);
    model_step(15, 1'b1, 3, 2, 15, mode_c, pc_m_c, oob_m_c);
    checking = 1'b1;
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("a.pc_out", pc_a, pc_m_a);
      checkOutput("a.pc_valid", valid_a, int'(mode_a == M_RUN));
      checkOutput("a.done", done_a, int'(mode_a == M_DONE));
      checkOutput("a.oob_err", oob_a, oob_m_a);
      checkOutput("b.pc_out", pc_b, pc_m_b);
      checkOutput("b.pc_valid", valid_b, int'(mode_b == M_RUN));
      checkOutput("b.done", done_b, int'(mode_b == M_DONE));
      checkOutput("b.oob_err", oob_b, oob_m_b);
      checkOutput("c.pc_out", pc_c, pc_m_c);
      checkOutput("c.pc_valid", valid_c, int'(mode_c == M_RUN));
      checkOutput("c.done", done_c, int'(mode_c == M_DONE));
      checkOutput("c.oob_err", oob_c, oob_m_c);
      checkOutput("a.valid_done_exclusive", int'(valid_a && done_a), 0);
    end
  end

  task automatic applyStimulus(input bit r, input bit s, input bit st, input bit bv,
                               input int tgt, input bit h, input int cycles);
    rst       = r;
    start     = s;
    stall     = st;
    br_valid  = bv;
    br_target = 8'(tgt);
    halt      = h;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int wrap_seq[4];
    wrap_seq = '{4, 5, 0, 1};

    applyStimulus(0, 0, 0, 0, 0, 0, 2);
    checkOutput("lit.reset_pc", pc_a, 0);
    checkOutput("lit.reset_valid", valid_a, 0);
    checkOutput("lit.reset_done", done_a, 0);

    applyStimulus(1, 1, 0, 0, 0, 0, 1);
    checkOutput("lit.start_pc", pc_a, 0);
    checkOutput("lit.start_valid", valid_a, 1);
    checkOutput("lit.start_pc_c", pc_c, 2);
    applyStimulus(1, 0, 0, 0, 0, 0, 3);
    checkOutput("lit.count_pc", pc_a, 3);
    checkOutput("lit.step3_pc_c", pc_c, 11);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 1);
      checkOutput("lit.wrap_pc_b", pc_b, wrap_seq[i]);
      checkOutput("lit.wrap_done_b", done_b, 0);
    end

    applyStimulus(1, 0, 0, 0, 0, 0, 8);
    checkOutput("lit.last_pc", pc_a, 15);
    checkOutput("lit.last_valid", valid_a, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 5);
    checkOutput("lit.end_pc_held", pc_a, 15);
    checkOutput("lit.end_done", done_a, 1);
    checkOutput("lit.end_valid", valid_a, 0);

    applyStimulus(1, 1, 0, 0, 0, 0, 1);
    checkOutput("lit.restart_pc", pc_a, 0);
    checkOutput("lit.restart_done", done_a, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 3);
    applyStimulus(1, 0, 0, 1, 9, 0, 1);
    checkOutput("lit.branch_pc", pc_a, 9);
    applyStimulus(1, 0, 0, 1, 200, 0, 1);
    checkOutput("lit.clamp_pc", pc_a, 15);
    checkOutput("lit.clamp_oob", oob_a, 1);
    applyStimulus(1, 0, 1, 1, 6, 0, 1);
    checkOutput("lit.branch_over_stall_pc", pc_a, 6);
    checkOutput("lit.oob_one_cycle", oob_a, 0);

    applyStimulus(1, 0, 1, 0, 0, 0, 3);
    checkOutput("lit.stall_pc", pc_a, 6);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    checkOutput("lit.resume_pc", pc_a, 7);
    applyStimulus(1, 0, 0, 1, 6, 0, 1);
    applyStimulus(1, 0, 0, 1, 2, 1, 1);
    checkOutput("lit.halt_pc", pc_a, 6);
    checkOutput("lit.halt_done", done_a, 1);
    applyStimulus(1, 0, 1, 1, 3, 1, 1);
    checkOutput("lit.done_ignores_pc", pc_a, 6);

    applyStimulus(1, 1, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 1, 11, 0, 1);
    checkOutput("lit.midrun_pc", pc_a, 11);
    applyStimulus(0, 0, 0, 1, 200, 0, 1);
    checkOutput("lit.midreset_pc", pc_a, 0);
    checkOutput("lit.midreset_valid", valid_a, 0);
    checkOutput("lit.midreset_oob", oob_a, 0);
    applyStimulus(1, 0, 1, 1, 4, 1, 3);
    checkOutput("lit.idle_ignores_pc", pc_a, 0);

    @(posedge clk);
    #1;
    $display("[TB] %0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
